// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Shares one I2C byte engine between NUM_REQ requesters. A requester wins
//   the bus with a START command (round-robin among START requesters). It
//   then owns the bus and issues commands until a STOP completes or the
//   engine reports ARB_LOST. Each command produces exactly one response
//   pulse on rsp_valid_o[owner].
//
//   Optional feature: define I2C_ARB_HOLD_TIMEOUT_EN to force a STOP when
//   the owner stays silent for HOLD_TIMEOUT cycles while holding the bus.
//   That STOP is answered with ERR.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/cmd_i/data_i  per-requester command, 3-bit code, 8-bit byte
//   req_ready_o             combinational accept for the current cycle
//   rsp_valid_o             one-cycle response strobe per requester
//   rsp_data_o/status_o     shared read byte and status (00 DONE 01 NAK
//                           10 ARB_LOST 11 ERR)
//   eng_cmd_*               command channel to the byte engine
//   eng_done_i/status_i/data_i  completion from the byte engine
//   owner_o, busy_o         current bus owner and bus-held flag
module i2c_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [3*NUM_REQ-1:0] req_cmd_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [7:0]           rsp_data_o,
    output logic [1:0]           rsp_status_o,
    output logic                 eng_cmd_valid_o,
    output logic [2:0]           eng_cmd_o,
    output logic [7:0]           eng_data_o,
    input  logic                 eng_cmd_ready_i,
    input  logic                 eng_done_i,
    input  logic [1:0]           eng_status_i,
    input  logic [7:0]           eng_data_i,
    output logic [2:0]           owner_o,
    output logic                 busy_o
);
    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [1:0] STS_ARB_LOST = 2'b10;
    localparam logic [1:0] STS_ERR      = 2'b11;

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_TIMEOUT < 1) begin : g_param_check
        $error("i2c_cmd_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_HOLD} state_e;

    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        logic legal;
        case (cmd)
            CMD_WRITE, CMD_READ_ACK, CMD_READ_NAK, CMD_START, CMD_STOP: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_status_q, rsp_status_d;
    logic                 eng_cmd_valid_q, eng_cmd_valid_d;
    logic [2:0]           eng_cmd_q, eng_cmd_d;
    logic [7:0]           eng_data_q, eng_data_d;

`ifdef I2C_ARB_HOLD_TIMEOUT_EN
    localparam int TMO_W = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HOLD_TIMEOUT - 1);
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_stop_q, tmo_stop_d;
`endif

    logic                 grant_found_s;
    logic [2:0]           grant_idx_s;
    logic [NUM_REQ-1:0]   grant_oh_s;
    logic [7:0]           grant_data_s;
    logic [NUM_REQ-1:0]   owner_oh_s;
    logic                 owner_valid_s;
    logic [2:0]           owner_cmd_s;
    logic [7:0]           owner_data_s;
    int                   best_dist_s;
    int                   dist_s;

    // Round-robin winner (smallest distance above rr_ptr) and owner channel mux
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = 3'd0;
        grant_oh_s    = '0;
        grant_data_s  = 8'h00;
        best_dist_s   = NUM_REQ;
        dist_s        = 0;
        owner_oh_s    = '0;
        owner_cmd_s   = 3'b000;
        owner_data_s  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            dist_s = (k + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
            if (req_valid_i[k] && (req_cmd_i[3*k +: 3] == CMD_START) && (dist_s < best_dist_s)) begin
                best_dist_s   = dist_s;
                grant_found_s = 1'b1;
                grant_idx_s   = 3'(k);
                grant_oh_s    = '0;
                grant_oh_s[k] = 1'b1;
                grant_data_s  = req_data_i[8*k +: 8];
            end else begin
                best_dist_s   = best_dist_s;
            end
            owner_oh_s[k] = (owner_q == 3'(k));
            owner_cmd_s   = owner_cmd_s | ({3{owner_oh_s[k]}} & req_cmd_i[3*k +: 3]);
            owner_data_s  = owner_data_s | ({8{owner_oh_s[k]}} & req_data_i[8*k +: 8]);
        end
        owner_valid_s = |(req_valid_i & owner_oh_s);
    end

    // Accept strobe: the IDLE winner, or the owner while it holds the bus
    always_comb begin
        case (state_q)
            S_IDLE:  req_ready_o = grant_found_s ? grant_oh_s : '0;
            S_HOLD:  req_ready_o = req_valid_i & owner_oh_s;
            default: req_ready_o = '0;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        busy_d          = busy_q;
        rsp_valid_d     = '0;
        rsp_data_d      = rsp_data_q;
        rsp_status_d    = rsp_status_q;
        eng_cmd_valid_d = eng_cmd_valid_q;
        eng_cmd_d       = eng_cmd_q;
        eng_data_d      = eng_data_q;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
        tmo_cnt_d       = '0;
        tmo_stop_d      = tmo_stop_q;
`endif
        case (state_q)
            S_IDLE: begin
                // busy_o stays high through the release response cycle, then drops
                if (grant_found_s) begin
                    owner_d         = grant_idx_s;
                    rr_ptr_d        = 3'((int'(grant_idx_s) + 1) % NUM_REQ);
                    busy_d          = 1'b1;
                    eng_cmd_valid_d = 1'b1;
                    eng_cmd_d       = CMD_START;
                    eng_data_d      = grant_data_s;
                    state_d         = S_ISSUE;
                end else begin
                    busy_d          = 1'b0;
                end
            end
            S_ISSUE: begin
                if (eng_cmd_ready_i) begin
                    eng_cmd_valid_d = 1'b0;
                    state_d         = S_WAIT_DONE;
                end else begin
                    eng_cmd_valid_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (eng_done_i) begin
                    rsp_valid_d = owner_oh_s;
                    rsp_data_d  = eng_data_i;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
                    rsp_status_d = tmo_stop_q ? STS_ERR : eng_status_i;
                    tmo_stop_d   = 1'b0;
`else
                    rsp_status_d = eng_status_i;
`endif
                    // NAK keeps ownership; only STOP or a lost arbitration releases
                    if ((eng_cmd_q == CMD_STOP) || (eng_status_i == STS_ARB_LOST)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_HOLD: begin
                if (owner_valid_s) begin
                    if (cmd_is_legal(owner_cmd_s)) begin
                        eng_cmd_valid_d = 1'b1;
                        eng_cmd_d       = owner_cmd_s;
                        eng_data_d      = owner_data_s;
                        state_d         = S_ISSUE;
                    end else begin
                        // Illegal code: answer ERR locally, engine untouched
                        rsp_valid_d  = owner_oh_s;
                        rsp_data_d   = 8'h00;
                        rsp_status_d = STS_ERR;
                    end
                end else begin
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LAST) begin
                        eng_cmd_valid_d = 1'b1;
                        eng_cmd_d       = CMD_STOP;
                        eng_data_d      = 8'h00;
                        tmo_stop_d      = 1'b1;
                        state_d         = S_ISSUE;
                    end else begin
                        tmo_cnt_d       = tmo_cnt_q + 1'b1;
                    end
`else
                    state_d = S_HOLD;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= 3'd0;
            owner_q         <= 3'd0;
            busy_q          <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= 8'h00;
            rsp_status_q    <= 2'b00;
            eng_cmd_valid_q <= 1'b0;
            eng_cmd_q       <= 3'b000;
            eng_data_q      <= 8'h00;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            tmo_stop_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            busy_q          <= busy_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_status_q    <= rsp_status_d;
            eng_cmd_valid_q <= eng_cmd_valid_d;
            eng_cmd_q       <= eng_cmd_d;
            eng_data_q      <= eng_data_d;
`ifdef I2C_ARB_HOLD_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            tmo_stop_q      <= tmo_stop_d;
`endif
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_status_o    = rsp_status_q;
    assign eng_cmd_valid_o = eng_cmd_valid_q;
    assign eng_cmd_o       = eng_cmd_q;
    assign eng_data_o      = eng_data_q;
    assign owner_o         = owner_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: directed scenarios followed by
// randomized sessions checked against a requester-level model (round-robin
// winner selection, release on STOP / ARB_LOST, ERR for illegal codes).
module tb_i2c_cmd_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;
    localparam logic [2:0] C_WR = 3'b001;
    localparam logic [2:0] C_RA = 3'b010;
    localparam logic [2:0] C_RN = 3'b011;
    localparam logic [2:0] C_ST = 3'b100;
    localparam logic [2:0] C_SP = 3'b101;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [3*N-1:0] req_cmd;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic [1:0]     rsp_status;
    logic           eng_cmd_valid;
    logic [2:0]     eng_cmd;
    logic [7:0]     eng_wdata;
    logic           eng_cmd_ready;
    logic           eng_done;
    logic [1:0]     eng_status;
    logic [7:0]     eng_rdata;
    logic [2:0]     owner;
    logic           busy;

    int             n_vec = 0;
    int             n_err = 0;
    int             model_rr = 0;
    logic [N-1:0]   waiting = '0;

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_cmd_i(req_cmd), .req_data_i(req_data),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
        .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
        .eng_cmd_valid_o(eng_cmd_valid), .eng_cmd_o(eng_cmd), .eng_data_o(eng_wdata),
        .eng_cmd_ready_i(eng_cmd_ready), .eng_done_i(eng_done),
        .eng_status_i(eng_status), .eng_data_i(eng_rdata),
        .owner_o(owner), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Model: first waiting START requester at or above the round-robin pointer
    function automatic int pick_winner(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            if (w[(model_rr + i) % N]) return (model_rr + i) % N;
        end
        return 0;
    endfunction

    function automatic bit is_legal(input logic [2:0] c);
        return (c >= 3'b001) && (c <= 3'b101);
    endfunction

    function automatic logic [1:0] rand_stat();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 2'b10;
            1, 2:    return 2'b01;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_req(input int k, input logic v, input logic [2:0] c, input logic [7:0] d);
        req_valid[k]        = v;
        req_cmd[3*k +: 3]   = c;
        req_data[8*k +: 8]  = d;
    endtask

    task automatic add_waiters(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i] && !waiting[i]) set_req(i, 1'b1, C_ST, 8'($urandom));
        end
        waiting = waiting | m;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_status"}, rsp_status, 0);
        chk({tag, "_eng_valid"}, eng_cmd_valid, 0);
        chk({tag, "_eng_cmd"}, eng_cmd, 0);
        chk({tag, "_eng_data"}, eng_wdata, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        req_valid = '0;
        req_cmd   = '0;
        req_data  = '0;
        waiting   = '0;
        rst       = 1'b1;
        step();
        chk_reset_outputs(tag);
        rst       = 1'b0;
        model_rr  = 0;
    endtask

    // Called in the cycle after acceptance; ends in the response cycle
    task automatic engine_xact(input int k, input logic [2:0] c, input logic [7:0] d,
                               input logic [1:0] st, input logic [7:0] rd);
        int w;
        chk("eng_valid", eng_cmd_valid, 1);
        chk("eng_cmd", eng_cmd, c);
        chk("eng_data", eng_wdata, d);
        chk("owner", owner, k);
        chk("busy_held", busy, 1);
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) begin
            step();
            chk("eng_stable_valid", eng_cmd_valid, 1);
            chk("eng_stable_cmd", eng_cmd, c);
        end
        eng_cmd_ready = 1'b1;
        step();
        eng_cmd_ready = 1'b0;
        chk("eng_valid_drop", eng_cmd_valid, 0);
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) begin
            step();
            chk("rsp_early", rsp_valid, 0);
        end
        eng_done   = 1'b1;
        eng_status = st;
        eng_rdata  = rd;
        step();
        eng_done   = 1'b0;
        eng_status = 2'b00;
        eng_rdata  = 8'($urandom);
        chk("rsp_valid", rsp_valid, onehot(k));
        chk("rsp_data", rsp_data, rd);
        chk("rsp_status", rsp_status, st);
        chk("busy_rsp", busy, 1);
    endtask

    task automatic grant_start(input logic [1:0] st, output int k, output bit rel);
        logic [7:0] d;
        logic [7:0] rd;
        #1;
        k = pick_winner(waiting);
        chk("grant_ready", req_ready, onehot(k));
        d = req_data[8*k +: 8];
        step();
        set_req(k, 1'b0, 3'b000, 8'h00);
        waiting[k] = 1'b0;
        model_rr   = (k + 1) % N;
        rd = 8'($urandom);
        engine_xact(k, C_ST, d, st, rd);
        rel = (st == 2'b10);
    endtask

    task automatic owner_cmd(input int k, input logic [2:0] c, input logic [7:0] d,
                             input logic [1:0] st, input logic [7:0] rd, output bit rel);
        set_req(k, 1'b1, c, d);
        #1;
        chk("hold_ready", req_ready, onehot(k));
        step();
        set_req(k, 1'b0, 3'b000, 8'h00);
        if (is_legal(c)) begin
            engine_xact(k, c, d, st, rd);
            rel = (c == C_SP) || (st == 2'b10);
        end else begin
            chk("err_valid", rsp_valid, onehot(k));
            chk("err_status", rsp_status, 2'b11);
            chk("err_no_eng", eng_cmd_valid, 0);
            rel = 1'b0;
        end
    endtask

    initial begin
        int k;
        bit rel;
        int n;
        logic [N-1:0] m;
        logic [2:0] cmd_tab [8];
        cmd_tab = '{C_WR, C_RA, C_RN, C_ST, C_SP, 3'b000, 3'b110, 3'b111};
        rst = 1'b1;
        req_valid = '0; req_cmd = '0; req_data = '0;
        eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_status = 2'b00; eng_rdata = 8'h00;
        step();
        do_reset("reset");

        // START / WRITE 0x44 / STOP by requester 0
        add_waiters(onehot(0));
        grant_start(2'b00, k, rel);
        owner_cmd(k, C_WR, 8'h44, 2'b00, 8'h00, rel);
        chk("wr_keep", rel, 0);
        owner_cmd(k, C_SP, 8'h00, 2'b00, 8'h00, rel);
        step();
        chk("busy_after_stop", busy, 0);

        // Non-START command from a non-owner waits unaccepted
        set_req(3, 1'b1, C_WR, 8'h12);
        #1;
        chk("nonstart_ready", req_ready, 0);
        step();
        chk("nonstart_no_eng", eng_cmd_valid, 0);
        set_req(3, 1'b0, 3'b000, 8'h00);

        // Simultaneous START from 1 and 2 after reset: 1 then 2
        do_reset("reset2");
        add_waiters(onehot(1) | onehot(2));
        grant_start(2'b00, k, rel);
        chk("rr_first", k, 1);
        owner_cmd(k, C_SP, 8'h00, 2'b00, 8'h00, rel);
        grant_start(2'b00, k, rel);
        chk("rr_second", k, 2);
        owner_cmd(k, C_SP, 8'h00, 2'b00, 8'h00, rel);
        step();

        // Owner 0 holds while requester 3 waits with START
        add_waiters(onehot(0));
        grant_start(2'b01, k, rel);
        add_waiters(onehot(3));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("waiter_blocked", req_ready, 0);
            step();
        end
        owner_cmd(k, C_WR, 8'h77, 2'b01, 8'h00, rel);
        owner_cmd(k, C_SP, 8'h00, 2'b00, 8'h00, rel);
        grant_start(2'b00, k, rel);
        chk("waiter_granted", k, 3);
        owner_cmd(k, C_SP, 8'h00, 2'b00, 8'h00, rel);
        step();

        // READ_NAK returns data; ARB_LOST on WRITE releases the bus
        add_waiters(onehot(0));
        grant_start(2'b00, k, rel);
        owner_cmd(k, C_RN, 8'h00, 2'b00, 8'hA5, rel);
        owner_cmd(k, C_WR, 8'h3C, 2'b10, 8'h00, rel);
        chk("arb_lost_release", rel, 1);
        step();
        chk("busy_after_arb_lost", busy, 0);

        // Illegal code, then reset while waiting for the engine
        add_waiters(onehot(1));
        grant_start(2'b00, k, rel);
        owner_cmd(k, 3'b111, 8'h00, 2'b00, 8'h00, rel);
        step();
        chk("err_no_eng_later", eng_cmd_valid, 0);
        set_req(k, 1'b1, C_WR, 8'h99);
        step();
        set_req(k, 1'b0, 3'b000, 8'h00);
        eng_cmd_ready = 1'b1;
        step();
        eng_cmd_ready = 1'b0;
        eng_done = 1'b1; eng_status = 2'b01; eng_rdata = 8'h5A;
        do_reset("reset_mid");
        eng_done = 1'b0; eng_status = 2'b00;
        step();
        chk("no_rsp_after_reset", rsp_valid, 0);

`ifdef I2C_ARB_HOLD_TIMEOUT_EN
        // Silent owner is forced off the bus with an internal STOP and ERR
        add_waiters(onehot(2));
        grant_start(2'b00, k, rel);
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_not_yet", eng_cmd_valid, 0);
        step();
        chk("tmo_valid", eng_cmd_valid, 1);
        chk("tmo_cmd", eng_cmd, C_SP);
        eng_cmd_ready = 1'b1;
        step();
        eng_cmd_ready = 1'b0;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("tmo_rsp_valid", rsp_valid, onehot(k));
        chk("tmo_rsp_status", rsp_status, 2'b11);
        step();
        chk("tmo_busy", busy, 0);
`endif

        // Randomized sessions against the requester-level model
        for (int s = 0; s < 25; s++) begin
            m = N'($urandom_range(0, (1 << N) - 1));
            if ((waiting | m) == '0) m = onehot($urandom_range(0, N - 1));
            add_waiters(m);
            grant_start(rand_stat(), k, rel);
            n = 0;
            while (!rel) begin
                if ($urandom_range(0, 3) == 0) add_waiters(onehot((k + 1 + $urandom_range(0, N - 2)) % N));
                owner_cmd(k, (n >= 3) ? C_SP : cmd_tab[$urandom_range(0, 7)], 8'($urandom),
                          rand_stat(), 8'($urandom), rel);
                n++;
            end
            if (waiting == '0) begin
                step();
                chk("rand_busy_low", busy, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
